// File: rtl/memctl_cfg_pkg.sv
// Shared encodings for the SDRAM controller boot-time configuration sequencer:
// FSM states and the AHB-Lite constants the sequencer drives.
package memctl_cfg_pkg;

  typedef enum logic [2:0] {
    ST_DLY  = 3'd0,
    ST_WA   = 3'd1,
    ST_WD   = 3'd2,
    ST_PA   = 3'd3,
    ST_PD   = 3'd4,
    ST_GAP  = 3'd5,
    ST_ERR  = 3'd6,
    ST_DONE = 3'd7
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

endpackage

// File: rtl/cfg_ahb_mux.sv
// Owner-select mux for the AHB-Lite master port: the sequencer drives the bus until
// handover, after which the CPU address/data signals and HREADY pass straight through.
module cfg_ahb_mux
  import memctl_cfg_pkg::*;
(
  input  logic        cpu_sel,
  input  logic [1:0]  seq_htrans,
  input  logic [31:0] seq_haddr,
  input  logic        seq_hwrite,
  input  logic [31:0] seq_hwdata,
  input  logic [31:0] cpu_haddr,
  input  logic [1:0]  cpu_htrans,
  input  logic        cpu_hwrite,
  input  logic [2:0]  cpu_hsize,
  input  logic [2:0]  cpu_hburst,
  input  logic [3:0]  cpu_hprot,
  input  logic [31:0] cpu_hwdata,
  input  logic        hready,
  output logic [31:0] bus_haddr,
  output logic [1:0]  bus_htrans,
  output logic        bus_hwrite,
  output logic [2:0]  bus_hsize,
  output logic [2:0]  bus_hburst,
  output logic [3:0]  bus_hprot,
  output logic [31:0] bus_hwdata,
  output logic        cpu_hready
);

  always_comb begin
    // NOTE: every output is assigned on both branches, so no latch can be inferred.
    if (cpu_sel) begin
      bus_haddr  = cpu_haddr;
      bus_htrans = cpu_htrans;
      bus_hwrite = cpu_hwrite;
      bus_hsize  = cpu_hsize;
      bus_hburst = cpu_hburst;
      bus_hprot  = cpu_hprot;
      bus_hwdata = cpu_hwdata;
      cpu_hready = hready;
    end else begin
      bus_haddr  = seq_haddr;
      bus_htrans = seq_htrans;
      bus_hwrite = seq_hwrite;
      bus_hsize  = HSIZE_WORD;
      bus_hburst = HBURST_SINGLE;
      bus_hprot  = HPROT_DATA;
      bus_hwdata = seq_hwdata;
      cpu_hready = 1'b0;
    end
  end

endmodule

// File: rtl/memctl_cfg_seq.sv
// Boot-time configuration sequencer: writes a fixed table of controller registers,
// polls a status register until its busy bits clear, then hands the bus to the CPU.
module memctl_cfg_seq #(
  parameter int                    NUM_CFG   = 4,
  parameter logic [NUM_CFG*32-1:0] CFG_ADDR  = '0,
  parameter logic [NUM_CFG*32-1:0] CFG_DATA  = '0,
  parameter logic [31:0]           POLL_ADDR = 32'h0,
  parameter logic [31:0]           POLL_MASK = 32'h1,
  parameter logic [15:0]           POLL_MAX  = 16'd1000,
  parameter logic [7:0]            START_DLY = 8'd16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] cpu_haddr,
  input  logic [1:0]  cpu_htrans,
  input  logic        cpu_hwrite,
  input  logic [2:0]  cpu_hsize,
  input  logic [2:0]  cpu_hburst,
  input  logic [3:0]  cpu_hprot,
  input  logic [31:0] cpu_hwdata,
  output logic        cpu_hready,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA,
  output logic        hsel_reg,
  output logic        cfg_done,
  output logic        cfg_err
);

  import memctl_cfg_pkg::*;

  localparam int               IDX_W    = $clog2(NUM_CFG + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CFG - 1);
  // A zero start delay is treated as a one-cycle delay.
  localparam logic [7:0]       DLY_LAST = (START_DLY == 8'd0) ? 8'd0 : START_DLY - 8'd1;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [7:0]       dly_cnt;
  logic [15:0]      poll_cnt;
  logic [15:0]      poll_cnt_inc;
  logic             poll_busy;

  logic [1:0]       seq_htrans;
  logic [31:0]      seq_haddr;
  logic             seq_hwrite;
  logic [31:0]      seq_hwdata;

  assign idx_nxt      = idx + IDX_W'(1);
  assign poll_cnt_inc = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;
  assign poll_busy    = (HRDATA & POLL_MASK) != 32'h0;

  // Outputs are registered: each transition loads the bus values of the state being entered.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= ST_DLY;
      idx        <= '0;
      dly_cnt    <= 8'd0;
      poll_cnt   <= 16'd0;
      seq_htrans <= HTRANS_IDLE;
      seq_haddr  <= 32'h0;
      seq_hwrite <= 1'b0;
      seq_hwdata <= 32'h0;
      hsel_reg   <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every branch reads the pre-edge register values.
      unique case (state)
        ST_DLY: begin
          if (dly_cnt == DLY_LAST) begin
            state      <= ST_WA;
            idx        <= '0;
            seq_htrans <= HTRANS_NONSEQ;
            seq_haddr  <= CFG_ADDR[31:0];
            seq_hwrite <= 1'b1;
            hsel_reg   <= 1'b1;
          end else begin
            dly_cnt <= dly_cnt + 8'd1;
          end
        end

        ST_WA: begin
          if (HREADY) begin
            state      <= ST_WD;
            seq_htrans <= HTRANS_IDLE;
            hsel_reg   <= 1'b0;
            seq_hwdata <= CFG_DATA[32*int'(idx) +: 32];
          end
        end

        ST_WD: begin
          if (HREADY) begin
            if (HRESP) begin
              state   <= ST_ERR;
              cfg_err <= 1'b1;
            end else if (idx == IDX_LAST) begin
              state      <= ST_PA;
              seq_htrans <= HTRANS_NONSEQ;
              seq_haddr  <= POLL_ADDR;
              seq_hwrite <= 1'b0;
              hsel_reg   <= 1'b1;
              poll_cnt   <= poll_cnt_inc;
            end else begin
              state      <= ST_WA;
              idx        <= idx_nxt;
              seq_htrans <= HTRANS_NONSEQ;
              seq_haddr  <= CFG_ADDR[32*int'(idx_nxt) +: 32];
              seq_hwrite <= 1'b1;
              hsel_reg   <= 1'b1;
            end
          end
        end

        ST_PA: begin
          if (HREADY) begin
            state      <= ST_PD;
            seq_htrans <= HTRANS_IDLE;
            hsel_reg   <= 1'b0;
          end
        end

        ST_PD: begin
          // An ERROR response is honoured only on its final (HREADY=1) cycle.
          if (HREADY) begin
            if (HRESP) begin
              state   <= ST_ERR;
              cfg_err <= 1'b1;
            end else if (!poll_busy) begin
              state    <= ST_DONE;
              cfg_done <= 1'b1;
            end else if (poll_cnt == POLL_MAX) begin
              state   <= ST_ERR;
              cfg_err <= 1'b1;
            end else begin
              state <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          state      <= ST_PA;
          seq_htrans <= HTRANS_NONSEQ;
          seq_haddr  <= POLL_ADDR;
          seq_hwrite <= 1'b0;
          hsel_reg   <= 1'b1;
          poll_cnt   <= poll_cnt_inc;
        end

        ST_ERR: begin
          state    <= ST_DONE;
          cfg_done <= 1'b1;
        end

        ST_DONE: begin
          state <= ST_DONE;
        end
      endcase
    end
  end

  // cfg_done doubles as the owner select: it rises only with no sequencer data phase pending.
  cfg_ahb_mux u_mux (
    .cpu_sel    (cfg_done),
    .seq_htrans (seq_htrans),
    .seq_haddr  (seq_haddr),
    .seq_hwrite (seq_hwrite),
    .seq_hwdata (seq_hwdata),
    .cpu_haddr  (cpu_haddr),
    .cpu_htrans (cpu_htrans),
    .cpu_hwrite (cpu_hwrite),
    .cpu_hsize  (cpu_hsize),
    .cpu_hburst (cpu_hburst),
    .cpu_hprot  (cpu_hprot),
    .cpu_hwdata (cpu_hwdata),
    .hready     (HREADY),
    .bus_haddr  (HADDR),
    .bus_htrans (HTRANS),
    .bus_hwrite (HWRITE),
    .bus_hsize  (HSIZE),
    .bus_hburst (HBURST),
    .bus_hprot  (HPROT),
    .bus_hwdata (HWDATA),
    .cpu_hready (cpu_hready)
  );

endmodule

// File: tb/tb_memctl_cfg_seq.sv
// Bench for memctl_cfg_seq: an AHB slave model with random wait states, busy polls and
// error responses; the expected transfer list and completion cycle are derived arithmetically.
module tb_memctl_cfg_seq;

  localparam int                    NUM_CFG   = 3;
  localparam logic [NUM_CFG*32-1:0] CFG_ADDR  = {32'h0000_0108, 32'h0000_0104, 32'h0000_0100};
  localparam logic [NUM_CFG*32-1:0] CFG_DATA  = {32'hCAFE_0003, 32'h1234_5602, 32'hA5A5_0001};
  localparam logic [31:0]           POLL_ADDR = 32'h0000_0200;
  localparam logic [31:0]           POLL_MASK = 32'h0000_0005;
  localparam int                    POLL_MAX  = 4;
  localparam int                    START_DLY = 5;
  localparam int                    EDGE_LIMIT = 300;

  localparam logic [1:0]  T_IDLE   = 2'b00;
  localparam logic [1:0]  T_NONSEQ = 2'b10;
  localparam logic [31:0] CPU_ADDR  = 32'h8000_0040;
  localparam logic [31:0] CPU_WDATA = 32'hDEAD_BEEF;

  logic [31:0] wr_addr_tbl [NUM_CFG] = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
  logic [31:0] wr_data_tbl [NUM_CFG] = '{32'hA5A5_0001, 32'h1234_5602, 32'hCAFE_0003};

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] cpu_haddr = CPU_ADDR;
  logic [1:0]  cpu_htrans = T_NONSEQ;
  logic        cpu_hwrite = 1'b1;
  logic [2:0]  cpu_hsize = 3'b001;
  logic [2:0]  cpu_hburst = 3'b011;
  logic [3:0]  cpu_hprot = 4'b1110;
  logic [31:0] cpu_hwdata = CPU_WDATA;
  logic        cpu_hready;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  logic [31:0] HRDATA = 32'h0;
  logic        hsel_reg;
  logic        cfg_done;
  logic        cfg_err;

  int checks = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  memctl_cfg_seq #(
    .NUM_CFG   (NUM_CFG),
    .CFG_ADDR  (CFG_ADDR),
    .CFG_DATA  (CFG_DATA),
    .POLL_ADDR (POLL_ADDR),
    .POLL_MASK (POLL_MASK),
    .POLL_MAX  (16'(POLL_MAX)),
    .START_DLY (8'(START_DLY))
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .cpu_haddr  (cpu_haddr),
    .cpu_htrans (cpu_htrans),
    .cpu_hwrite (cpu_hwrite),
    .cpu_hsize  (cpu_hsize),
    .cpu_hburst (cpu_hburst),
    .cpu_hprot  (cpu_hprot),
    .cpu_hwdata (cpu_hwdata),
    .cpu_hready (cpu_hready),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HBURST     (HBURST),
    .HPROT      (HPROT),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA),
    .hsel_reg   (hsel_reg),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] busy_word();
    logic [31:0] bit_sel;
    bit_sel = ($urandom_range(0, 1) == 0) ? 32'h1 : 32'h4;
    return ($urandom & ~POLL_MASK) | bit_sel;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_htrans"}, HTRANS, T_IDLE);
    check({tag, "_haddr"}, HADDR, 32'h0);
    check({tag, "_hwdata"}, HWDATA, 32'h0);
    check({tag, "_hwrite"}, HWRITE, 1'b0);
    check({tag, "_hsize"}, HSIZE, 3'b010);
    check({tag, "_hburst"}, HBURST, 3'b000);
    check({tag, "_hprot"}, HPROT, 4'b0011);
    check({tag, "_hsel"}, hsel_reg, 1'b0);
    check({tag, "_cpu_hready"}, cpu_hready, 1'b0);
    check({tag, "_cfg_done"}, cfg_done, 1'b0);
    check({tag, "_cfg_err"}, cfg_err, 1'b0);
  endtask

  // One boot sequence: w wait states per data phase, busy_k busy poll reads, error on
  // write err_wr (-1: none), reset asserted during the data phase of write abort_wr (-1: none).
  task automatic run_seq(input int w, input int busy_k, input int err_wr, input int abort_wr);
    int edge_n, done_edge, wr_seen, rd_seen, dp_cyc, n_wr, n_rd, exp_edge, n_cmp;
    bit dp_active, dp_write, dp_err, done_seen, aborted, exp_err, timeout;
    logic [1:0]  s_htrans;
    logic [31:0] s_haddr;
    logic        s_hwrite, s_hready;
    logic [31:0] obs_addr[$];
    bit          obs_write[$];
    logic [31:0] exp_addr[$];
    bit          exp_write[$];

    edge_n = 0; done_edge = 0; wr_seen = 0; rd_seen = 0; dp_cyc = 0;
    dp_active = 0; dp_write = 0; dp_err = 0; done_seen = 0; aborted = 0;

    @(negedge HCLK);
    HRESETn = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
    #1 check_reset_vals("reset");
    @(negedge HCLK);
    HRESETn = 1'b1;

    while (!done_seen && !aborted && edge_n < EDGE_LIMIT) begin
      if (dp_active) begin
        if (dp_err && dp_cyc == w) begin HREADY = 1'b0; HRESP = 1'b1; end
        else if (dp_err && dp_cyc == w + 1) begin HREADY = 1'b1; HRESP = 1'b1; end
        else if (dp_cyc < w) begin HREADY = 1'b0; HRESP = 1'b0; end
        else begin HREADY = 1'b1; HRESP = 1'b0; end
        if (!dp_write && HREADY) HRDATA = (rd_seen <= busy_k) ? busy_word() : ($urandom & ~POLL_MASK);
        else HRDATA = $urandom;
      end else begin
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
      end
      #1;
      check("cpu_hready_stalled", cpu_hready, 1'b0);
      if (edge_n < START_DLY) check("htrans_in_delay", HTRANS, T_IDLE);
      if (HTRANS == T_NONSEQ) check("hsel_addr_phase", hsel_reg, 1'b1);
      if (dp_active) begin
        check("htrans_data_phase", HTRANS, T_IDLE);
        check("hsel_data_phase", hsel_reg, 1'b0);
        if (dp_write && wr_seen >= 1 && wr_seen <= NUM_CFG)
          check("hwdata_data_phase", HWDATA, wr_data_tbl[wr_seen-1]);
      end

      if (dp_active && dp_write && (wr_seen - 1) == abort_wr) begin
        HRESETn = 1'b0;
        #1 check_reset_vals("abort");
        aborted = 1;
      end else begin
        s_htrans = HTRANS; s_haddr = HADDR; s_hwrite = HWRITE; s_hready = HREADY;
        @(posedge HCLK);
        edge_n++;
        if (dp_active) begin
          if (s_hready) dp_active = 0;
          else dp_cyc++;
        end
        if (s_htrans == T_NONSEQ && s_hready) begin
          obs_addr.push_back(s_haddr);
          obs_write.push_back(s_hwrite);
          dp_active = 1; dp_cyc = 0; dp_write = s_hwrite;
          if (s_hwrite) begin wr_seen++; dp_err = ((wr_seen - 1) == err_wr); end
          else begin rd_seen++; dp_err = 0; end
        end
        #1;
        if (cfg_done === 1'b1) begin done_seen = 1; done_edge = edge_n; end
        else @(negedge HCLK);
      end
    end

    if (!aborted) begin
      check("done_reached", done_seen, 1'b1);
      timeout = (err_wr < 0) && (busy_k >= POLL_MAX);
      n_wr    = (err_wr >= 0) ? err_wr + 1 : NUM_CFG;
      n_rd    = (err_wr >= 0) ? 0 : (timeout ? POLL_MAX : busy_k + 1);
      exp_err = (err_wr >= 0) || timeout;
      for (int i = 0; i < n_wr; i++) begin exp_addr.push_back(wr_addr_tbl[i]); exp_write.push_back(1'b1); end
      for (int i = 0; i < n_rd; i++) begin exp_addr.push_back(POLL_ADDR); exp_write.push_back(1'b0); end
      if (err_wr >= 0) exp_edge = START_DLY + err_wr * (2 + w) + (3 + w) + 1;
      else exp_edge = START_DLY + (n_wr + n_rd) * (2 + w) + (n_rd - 1) + (timeout ? 1 : 0);

      check("xfer_count", obs_addr.size(), exp_addr.size());
      n_cmp = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
      for (int i = 0; i < n_cmp; i++) begin
        check("xfer_addr", obs_addr[i], exp_addr[i]);
        check("xfer_write", obs_write[i], exp_write[i]);
      end
      check("done_cycle", done_edge, exp_edge);
      check("cfg_err", cfg_err, exp_err);

      // CPU address phase held from reset appears the cycle cfg_done rises.
      check("ho_haddr", HADDR, CPU_ADDR);
      check("ho_htrans", HTRANS, T_NONSEQ);
      check("ho_hwrite", HWRITE, 1'b1);
      check("ho_hsize", HSIZE, 3'b001);
      check("ho_hburst", HBURST, 3'b011);
      check("ho_hprot", HPROT, 4'b1110);
      check("ho_hwdata", HWDATA, CPU_WDATA);
      HREADY = 1'b0;
      #1 check("ho_hready_lo", cpu_hready, 1'b0);
      HREADY = 1'b1;
      #1 check("ho_hready_hi", cpu_hready, 1'b1);
      for (int i = 0; i < 3; i++) begin
        @(negedge HCLK);
        check("done_sticky", cfg_done, 1'b1);
        check("err_sticky", cfg_err, exp_err);
        check("hsel_after_done", hsel_reg, 1'b0);
      end
    end
  endtask

  initial begin
    run_seq(0, 0, -1, -1);                  // plain sequence, zero-wait slave
    run_seq(3, 0, -1, -1);                  // 3 wait states in every data phase
    run_seq(0, 5, -1, -1);                  // busy polls beyond POLL_MAX -> timeout
    run_seq(1, 2, -1, -1);                  // two busy reads then ready
    run_seq(0, POLL_MAX - 1, -1, -1);       // ready on the last permitted read
    run_seq(0, POLL_MAX, -1, -1);           // busy on exactly POLL_MAX reads -> timeout
    run_seq(1, 0, 1, -1);                   // ERROR response on write idx 1
    run_seq(2, 0, 0, -1);                   // ERROR response on the first write
    run_seq(1, 0, -1, 1);                   // reset during a write data phase
    run_seq(0, 1, -1, -1);                  // full replay after the abort
    for (int r = 0; r < 4; r++) begin
      int w_r, busy_r, err_r;
      w_r    = int'($urandom_range(0, 3));
      busy_r = int'($urandom_range(0, 6));
      err_r  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NUM_CFG - 1)) : -1;
      run_seq(w_r, busy_r, err_r, -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
